// File: rtl/de_morgan_pkg.sv
// Op codes shared by the logic unit and its evaluator.
// Codes are fixed by the interface to the test sequencer; do not renumber.
package de_morgan_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOR   = 3'd0;
  localparam logic [OP_W-1:0] OP_NAND  = 3'd1;
  localparam logic [OP_W-1:0] OP_OR    = 3'd2;
  localparam logic [OP_W-1:0] OP_AND   = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_PASSA = 3'd6;
  localparam logic [OP_W-1:0] OP_NOTA  = 3'd7;

endpackage

// File: rtl/de_morgan_eval.sv
// Combinational evaluator: each op in direct form and in its De Morgan dual form.
// Zero latency, no flow control; the caller compares the two results.
module de_morgan_eval
  import de_morgan_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y_direct,
  output logic [WIDTH-1:0] y_dual
);

  always_comb begin
    y_direct = '0;
    y_dual   = '0;
    case (op)
      OP_NOR: begin
        y_direct = ~(a | b);
        y_dual   = ~a & ~b;
      end
      OP_NAND: begin
        y_direct = ~(a & b);
        y_dual   = ~a | ~b;
      end
      OP_OR: begin
        y_direct = a | b;
        y_dual   = ~(~a & ~b);
      end
      OP_AND: begin
        y_direct = a & b;
        y_dual   = ~(~a | ~b);
      end
      OP_XOR: begin
        y_direct = a ^ b;
        y_dual   = (a | b) & ~(a & b);
      end
      OP_XNOR: begin
        y_direct = ~(a ^ b);
        y_dual   = (a & b) | (~a & ~b);
      end
      OP_PASSA: begin
        y_direct = a;
        y_dual   = ~(~a);
      end
      default: begin
        y_direct = ~a;
        y_dual   = ~a;
      end
    endcase
  end

endmodule

// File: rtl/de_morgan_logic_unit.sv
// Self-checking bitwise logic unit: 2-stage valid/ready pipeline, result one edge after accept.
// Stalls from out_ready ripple back combinationally to in_ready; holds up to 2 beats.
module de_morgan_logic_unit
  import de_morgan_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             fault_inj,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             mismatch,
  input  logic             clr_count,
  output logic [CNT_W-1:0] err_count
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [OP_W-1:0]  s1_op;
  logic             s1_fault;

  logic             s2_loads;
  logic             s1_loads;
  logic [WIDTH-1:0] y_direct;
  logic [WIDTH-1:0] y_dual;
  logic [WIDTH-1:0] fault_mask;
  logic             out_hs;

  assign s2_loads = !out_valid || out_ready;
  assign s1_loads = !s1_valid || s2_loads;
  assign in_ready = s1_loads;
  assign out_hs   = out_valid && out_ready;

  // Mask built bit-wise so WIDTH=1 needs no zero-width replication.
  always_comb begin
    fault_mask    = '0;
    fault_mask[0] = s1_fault;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_fault <= 1'b0;
    end else if (s1_loads) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a     <= a;
        s1_b     <= b;
        s1_op    <= op;
        s1_fault <= fault_inj;
      end
    end
  end

  de_morgan_eval #(
    .WIDTH (WIDTH)
  ) u_eval (
    .a        (s1_a),
    .b        (s1_b),
    .op       (s1_op),
    .y_direct (y_direct),
    .y_dual   (y_dual)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      y         <= '0;
      mismatch  <= 1'b0;
    end else if (s2_loads) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        y        <= y_direct;
        mismatch <= (y_direct != (y_dual ^ fault_mask));
      end
    end
  end

  // Clear beats a same-cycle increment; count sticks at all-ones.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_count <= '0;
    end else if (clr_count) begin
      err_count <= '0;
    end else if (out_hs && mismatch && (err_count != '1)) begin
      err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_de_morgan_logic_unit.sv
// Directed bench for de_morgan_logic_unit; a second instance with CNT_W=2 checks saturation.
module tb_de_morgan_logic_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [2:0]  op = '0;
  logic        fault_inj = 1'b0;
  logic        out_ready = 1'b1;
  logic        clr_count = 1'b0;

  logic        in_ready, out_valid, mismatch;
  logic [7:0]  y;
  logic [15:0] err_count;
  logic        in_ready_sat, out_valid_sat, mismatch_sat;
  logic [7:0]  y_sat;
  logic [1:0]  err_count_sat;

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;

  logic [8:0] res_q[$];
  int         cyc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  de_morgan_logic_unit #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .fault_inj(fault_inj),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .mismatch(mismatch),
    .clr_count(clr_count), .err_count(err_count)
  );

  de_morgan_logic_unit #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready_sat),
    .a(a), .b(b), .op(op), .fault_inj(fault_inj),
    .out_valid(out_valid_sat), .out_ready(out_ready), .y(y_sat), .mismatch(mismatch_sat),
    .clr_count(clr_count), .err_count(err_count_sat)
  );

  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      res_q.push_back({mismatch, y});
      cyc_q.push_back(cycle);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                          input logic f);
    in_valid = 1'b1; op = o; a = aa; b = bb; fault_inj = f;
  endtask

  // Offer one beat and return just after the edge that accepts it.
  task automatic send(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                      input logic f);
    int g;
    set_beat(o, aa, bb, f);
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    tick(1);
  endtask

  task automatic idle();
    in_valid = 1'b0; fault_inj = 1'b0;
  endtask

  logic [7:0] sweep_exp [8] = '{8'h50, 8'hFA, 8'hAF, 8'h05, 8'hAA, 8'h55, 8'hA5, 8'h5A};
  logic [2:0] st_op [4] = '{3'd0, 3'd3, 3'd4, 3'd7};
  logic [7:0] st_a  [4] = '{8'h00, 8'hF0, 8'hF0, 8'h12};
  logic [7:0] st_b  [4] = '{8'h00, 8'h3C, 8'h3C, 8'h99};
  logic [7:0] st_y  [4] = '{8'hFF, 8'h30, 8'hCC, 8'hED};

  function automatic logic [7:0] ref_y(input logic [2:0] o, input logic [7:0] aa,
                                       input logic [7:0] bb);
    case (o)
      3'd0: return ~(aa | bb);
      3'd1: return ~(aa & bb);
      3'd2: return aa | bb;
      3'd3: return aa & bb;
      3'd4: return aa ^ bb;
      3'd5: return ~(aa ^ bb);
      3'd6: return aa;
      default: return ~aa;
    endcase
  endfunction

  initial begin
    logic [7:0] yhold;
    logic       have, acc;
    int         bi, g;

    // Reset state
    tick(3);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y", {24'd0, y}, 32'd0);
    check("rst_mismatch", {31'd0, mismatch}, 32'd0);
    check("rst_err_count", {16'd0, err_count}, 32'd0);
    resetn = 1'b1;
    tick(1);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // First-beat latency: accepted at edge N, visible after edge N+1
    send(3'd0, 8'hA5, 8'h0F, 1'b0);
    idle();
    check("lat_not_early", {31'd0, out_valid}, 32'd0);
    tick(1);
    check("lat_out_valid", {31'd0, out_valid}, 32'd1);
    check("lat_y", {24'd0, y}, 32'h50);
    tick(2);
    res_q.delete(); cyc_q.delete();

    // Op sweep with A5/0F
    for (int i = 0; i < 8; i++) send(3'(i), 8'hA5, 8'h0F, 1'b0);
    idle();
    tick(4);
    check("sweep_count", res_q.size(), 32'd8);
    for (int i = 0; i < 8 && i < res_q.size(); i++) begin
      check($sformatf("sweep_y_op%0d", i), {23'd0, res_q[i]}, {24'd0, sweep_exp[i]});
    end
    res_q.delete(); cyc_q.delete();

    // 16 back-to-back beats
    for (int i = 0; i < 16; i++) send(3'(i % 8), 8'(i * 17), 8'(8'hC3 ^ i), 1'b0);
    idle();
    tick(4);
    check("b2b_count", res_q.size(), 32'd16);
    if (res_q.size() == 16) begin
      for (int i = 0; i < 16; i++)
        check($sformatf("b2b_y%0d", i), {23'd0, res_q[i]},
              {24'd0, ref_y(3'(i % 8), 8'(i * 17), 8'(8'hC3 ^ i))});
      check("b2b_consecutive", cyc_q[15] - cyc_q[0], 32'd15);
    end
    res_q.delete(); cyc_q.delete();

    // Backpressure: 5 stalled cycles with 4 beats offered
    out_ready = 1'b0; bi = 0; have = 1'b0;
    set_beat(st_op[0], st_a[0], st_b[0], 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); acc = in_ready;
      tick(1);
      if (acc) begin
        bi++;
        if (bi < 4) set_beat(st_op[bi], st_a[bi], st_b[bi], 1'b0);
      end
      if (out_valid) begin
        if (!have) begin yhold = y; have = 1'b1; end
        else check("stall_y_stable", {24'd0, y}, {24'd0, yhold});
      end
    end
    check("stall_accepts", bi, 32'd2);
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1; g = 0;
    while (bi < 4 && g < 50) begin
      @(negedge clk); acc = in_ready;
      tick(1); g++;
      if (acc) begin
        bi++;
        if (bi < 4) set_beat(st_op[bi], st_a[bi], st_b[bi], 1'b0);
      end
    end
    idle();
    tick(4);
    check("bp_count", res_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < res_q.size(); i++)
      check($sformatf("bp_y%0d", i), {23'd0, res_q[i]}, {24'd0, st_y[i]});
    res_q.delete(); cyc_q.delete();

    // Fault injection: mismatch flagged, y unaffected
    for (int i = 0; i < 3; i++) send(3'd3, 8'hFF, 8'hFF, 1'b1);
    send(3'd3, 8'hFF, 8'hFF, 1'b0);
    idle();
    tick(4);
    check("fault_count", res_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < res_q.size(); i++)
      check($sformatf("fault_beat%0d", i), {23'd0, res_q[i]}, (i < 3) ? 32'h1FF : 32'h0FF);
    check("fault_err_count", {16'd0, err_count}, 32'd3);
    check("fault_err_sat", {30'd0, err_count_sat}, 32'd3);

    // Clear on the same edge as a mismatching handshake
    out_ready = 1'b0;
    send(3'd3, 8'hFF, 8'hFF, 1'b1);
    idle();
    tick(1);
    check("clr_pending_valid", {31'd0, out_valid & mismatch}, 32'd1);
    clr_count = 1'b1; out_ready = 1'b1;
    tick(1);
    clr_count = 1'b0;
    check("clr_wins", {16'd0, err_count}, 32'd0);
    tick(2);
    res_q.delete(); cyc_q.delete();

    // Saturation on the CNT_W=2 instance
    for (int i = 0; i < 2; i++) send(3'd3, 8'hFF, 8'hFF, 1'b1);
    idle();
    tick(3);
    check("sat_two", {30'd0, err_count_sat}, 32'd2);
    for (int i = 0; i < 3; i++) send(3'd3, 8'hFF, 8'hFF, 1'b1);
    idle();
    tick(3);
    check("sat_hold", {30'd0, err_count_sat}, 32'd3);
    check("sat_wide_count", {16'd0, err_count}, 32'd5);
    res_q.delete(); cyc_q.delete();

    // Reset mid-stream discards in-flight beats
    out_ready = 1'b0;
    send(3'd2, 8'h11, 8'h22, 1'b1);
    send(3'd2, 8'h33, 8'h44, 1'b1);
    idle();
    resetn = 1'b0;
    tick(3);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_err_count", {16'd0, err_count}, 32'd0);
    resetn = 1'b1; out_ready = 1'b1;
    tick(3);
    check("mid_rst_no_output", res_q.size(), 32'd0);
    send(3'd5, 8'hA5, 8'h0F, 1'b0);
    idle();
    check("mid_rst_lat_early", {31'd0, out_valid}, 32'd0);
    tick(1);
    check("mid_rst_lat_valid", {31'd0, out_valid}, 32'd1);
    check("mid_rst_lat_y", {24'd0, y}, 32'h55);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
